// File: rtl/blink_pkg.sv
// Shared types and helpers for LED status blocks: FSM state encoding and timer sizing.
package blink_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} blink_state_t;

  // Bits needed for a down-counter that must hold the largest of three phase lengths.
  function automatic int timer_w(input longint a, input longint b, input longint c);
    longint m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/blink_count_tx_cycle_timer.sv
// Loadable down-counter that stops at zero; expired is high while the count is zero.
module cycle_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/blink_count_tx.sv
// Replays a captured count as N visible LED blinks followed by a dark gap, then pulses done.
module blink_count_tx
  import blink_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int GAP_CYCLES = 50_000_000
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count_in,
  output logic             ready,
  output logic             led_out,
  output logic             done
);

  localparam int TW = timer_w(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
  // Timer is loaded with length-1 so each phase lasts exactly its cycle count.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  blink_state_t     state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             ready_q, ready_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expired;

  cycle_timer #(.TW(TW)) u_timer (
    .clk      (sysclk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tmr_load    = 1'b1;
          remaining_d = count_in;
          if (count_in != '0) begin
            state_d = ON;
            tmr_val = ON_LOAD;
          end else begin
            state_d = GAP;
            tmr_val = GAP_LOAD;
          end
        end
      end
      ON: begin
        if (tmr_expired) begin
          tmr_load    = 1'b1;
          remaining_d = remaining_q - WIDTH'(1);
          // Last blink goes straight to the gap; no trailing OFF phase.
          if (remaining_q != WIDTH'(1)) begin
            state_d = OFF;
            tmr_val = OFF_LOAD;
          end else begin
            state_d = GAP;
            tmr_val = GAP_LOAD;
          end
        end
      end
      OFF: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
          state_d  = ON;
        end
      end
      GAP: begin
        if (tmr_expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    led_d   = (state_d == ON);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      ready_q     <= 1'b1;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ready_q     <= ready_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  assign ready   = ready_q;
  assign led_out = led_q;
  assign done    = done_q;

endmodule

// File: tb/tb_blink_count_tx.sv
// Directed bench for blink_count_tx with short phase lengths (ON=3, OFF=2, GAP=5).
module tb_blink_count_tx;

  localparam int W    = 4;
  localparam int ONC  = 3;
  localparam int OFFC = 2;
  localparam int GAPC = 5;

  logic         sysclk = 1'b0;
  logic         reset  = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] count_in = '0;
  logic         ready, led_out, done;

  int total = 0;
  int bad   = 0;

  logic led_a   [0:127];
  logic done_a  [0:127];
  logic ready_a [0:127];

  typedef struct {
    logic [W-1:0] cnt;
    int           n_blinks;
    int           done_cyc;
  } vec_t;

  vec_t vecs [5];

  always #5 sysclk = ~sysclk;

  blink_count_tx #(
    .WIDTH      (W),
    .ON_CYCLES  (ONC),
    .OFF_CYCLES (OFFC),
    .GAP_CYCLES (GAPC)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .start    (start),
    .count_in (count_in),
    .ready    (ready),
    .led_out  (led_out),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge sysclk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  // Accept a start at edge 0, then record cycles 1..len at the falling edge.
  task automatic run(input logic [W-1:0] cnt, input bit hold, input int poke_c, input int len);
    wait_ready();
    start    = 1'b1;
    count_in = cnt;
    @(posedge sysclk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge sysclk);
      led_a[c]   = led_out;
      done_a[c]  = done;
      ready_a[c] = ready;
      if (poke_c != 0 && c == poke_c) begin
        start    = 1'b1;
        count_in = 4'd7;
      end else if (poke_c != 0 && c == poke_c + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic analyse(input string tag, input int n, input int done_cyc);
    int   led_err, rises, ready_err, early_done, p;
    logic prev, exp_lit;
    led_err = 0; rises = 0; ready_err = 0; early_done = 0;
    prev = 1'b0;
    for (int c = 1; c < done_cyc; c++) begin
      p = c - 1;
      exp_lit = (n > 0) && (p / (ONC + OFFC) < n) && (p % (ONC + OFFC) < ONC);
      if (led_a[c] !== exp_lit) led_err++;
      if (led_a[c] === 1'b1 && prev === 1'b0) rises++;
      prev = led_a[c];
      if (ready_a[c] !== 1'b0) ready_err++;
      if (done_a[c] !== 1'b0) early_done++;
    end
    check({tag, "_led_pattern_errs"}, led_err, 0);
    check({tag, "_rises"}, rises, n);
    check({tag, "_busy_ready_errs"}, ready_err, 0);
    check({tag, "_early_done"}, early_done, 0);
    check({tag, "_done_at_end"}, {31'd0, done_a[done_cyc]}, 1);
    check({tag, "_ready_at_end"}, {31'd0, ready_a[done_cyc]}, 1);
  endtask

  initial begin
    vecs[0] = '{cnt: 4'd2,  n_blinks: 2,  done_cyc: 14};
    vecs[1] = '{cnt: 4'd0,  n_blinks: 0,  done_cyc: 6};
    vecs[2] = '{cnt: 4'd1,  n_blinks: 1,  done_cyc: 9};
    vecs[3] = '{cnt: 4'd5,  n_blinks: 5,  done_cyc: 29};
    vecs[4] = '{cnt: 4'd15, n_blinks: 15, done_cyc: 79};

    reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_led", {31'd0, led_out}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge sysclk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run(vecs[i].cnt, 1'b0, 0, vecs[i].done_cyc + 2);
      analyse($sformatf("vec%0d", i), vecs[i].n_blinks, vecs[i].done_cyc);
      check($sformatf("vec%0d_done_one_cycle", i),
            {31'd0, done_a[vecs[i].done_cyc + 1]}, 0);
    end

    // Start during a running sequence (with a new count) must be ignored.
    run(4'd2, 1'b0, 4, 16);
    analyse("ignore_busy_start", 2, 14);
    check("ignore_done_one_cycle", {31'd0, done_a[15]}, 0);

    // Held start: next sequence begins on the done cycle with no idle gap.
    run(4'd1, 1'b1, 0, 10);
    analyse("held_start", 1, 9);
    check("held_next_led", {31'd0, led_a[10]}, 1);
    start = 1'b0;

    // Asynchronous reset in cycle 5 of a count=3 run.
    run(4'd3, 1'b0, 0, 4);
    check("midrst_led_c2", {31'd0, led_a[2]}, 1);
    @(negedge sysclk);
    check("midrst_busy_c5", {31'd0, ready}, 0);
    reset = 1'b0;
    #1;
    check("midrst_led", {31'd0, led_out}, 0);
    check("midrst_ready", {31'd0, ready}, 1);
    check("midrst_done", {31'd0, done}, 0);
    begin
      int dcnt;
      dcnt = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge sysclk);
        if (done !== 1'b0 || led_out !== 1'b0) dcnt++;
      end
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge sysclk);
        if (done !== 1'b0 || led_out !== 1'b0) dcnt++;
      end
      check("midrst_quiet_after", dcnt, 0);
    end
    run(4'd1, 1'b0, 0, 11);
    analyse("post_rst", 1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
